mul_issue_unit: RTL and testbench

MUL_ISSUE_UNIT -- requirements
Module: mul_issue_unit

---
 rtl/mul_issue_unit_pkg.sv | 18 +
 rtl/mul_decode.sv | 27 ++
 rtl/mul_issue_unit.sv | 122 ++++++++++++
 tb/tb_mul_issue_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_unit_pkg.sv
// Shared types and constants for the RV32M multiply issue unit.
package mul_issue_unit_pkg;

    localparam int RES_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

endpackage

// File: rtl/mul_decode.sv
// Maps RV32M funct3 to multiplier operand signedness and high-word select.
// Combinational, no state, no backpressure; any funct3 with bit 2 set is flagged as an error.
module mul_decode
    import mul_issue_unit_pkg::*;
(
    input  logic [2:0] funct3,
    output logic       signed_a,
    output logic       signed_b,
    output logic       upper,
    output logic       err
);

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        upper    = 1'b0;
        err      = 1'b0;
        case (funct3)
            F3_MUL:    ;
            F3_MULH:   begin signed_a = 1'b1; signed_b = 1'b1; upper = 1'b1; end
            F3_MULHSU: begin signed_a = 1'b1; upper = 1'b1; end
            F3_MULHU:  upper = 1'b1;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/mul_issue_unit.sv
// Issues RV32M multiplies to an external multiplier, with a one-entry result cache.
// Latency: cache hit or DIV/REM error 1 cycle after accept; miss responds the cycle after mult_done_i.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held until rsp_ready_i.
module mul_issue_unit
    import mul_issue_unit_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [RES_W-1:0] rs1_i,
    input  logic [RES_W-1:0] rs2_i,
    input  logic [4:0]       rd_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [RES_W-1:0] rsp_data_o,
    output logic [4:0]       rsp_rd_o,
    output logic             rsp_err_o,
    output logic             mult_en_o,
    output logic [RES_W-1:0] op_A_o,
    output logic [RES_W-1:0] op_B_o,
    output logic             signed_A_o,
    output logic             signed_B_o,
    output logic             upper_o,
    input  logic             mult_done_i,
    input  logic [RES_W-1:0] mult_result_i
);

    state_t           state;
    logic [2:0]       f3_q;
    logic             dec_sa, dec_sb, dec_up, dec_err;
    logic [RES_W-1:0] c_a, c_b, c_result;
    logic [2:0]       c_f3;
    logic             c_valid;
    logic             hit;

    mul_decode u_decode (
        .funct3   (funct3_i),
        .signed_a (dec_sa),
        .signed_b (dec_sb),
        .upper    (dec_up),
        .err      (dec_err)
    );

    assign req_ready_o = (state == IDLE);
    assign hit = c_valid && (c_a == rs1_i) && (c_b == rs2_i) && (c_f3 == funct3_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            f3_q        <= 3'd0;
            op_A_o      <= '0;
            op_B_o      <= '0;
            signed_A_o  <= 1'b0;
            signed_B_o  <= 1'b0;
            upper_o     <= 1'b0;
            mult_en_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_rd_o    <= 5'd0;
            rsp_err_o   <= 1'b0;
            c_valid     <= 1'b0;
            c_a         <= '0;
            c_b         <= '0;
            c_f3        <= 3'd0;
            c_result    <= '0;
        end else begin
            mult_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_A_o     <= rs1_i;
                        op_B_o     <= rs2_i;
                        f3_q       <= funct3_i;
                        rsp_rd_o   <= rd_i;
                        signed_A_o <= dec_sa;
                        signed_B_o <= dec_sb;
                        upper_o    <= dec_up;
                        if (dec_err) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                            state       <= RESP;
                        end else if (hit) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_data_o  <= c_result;
                            state       <= RESP;
                        end else begin
                            mult_en_o <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // Only a done seen here belongs to our operation; strays elsewhere are dropped.
                    if (mult_done_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= mult_result_i;
                        c_valid     <= 1'b1;
                        c_a         <= op_A_o;
                        c_b         <= op_B_o;
                        c_f3        <= f3_q;
                        c_result    <= mult_result_i;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit against a modelled 7-cycle multiplier.
module tb_mul_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        mult_en;
    logic [31:0] op_a, op_b;
    logic        signed_a, signed_b, upper;
    logic        mult_done;
    logic [31:0] mult_result;

    logic        mdl_done = 1'b0;
    logic [31:0] mdl_res = 32'd0;
    logic [3:0]  mdl_cnt = 4'd0;
    logic        stray_done = 1'b0;
    int          en_count = 0;

    int total = 0;
    int fails = 0;
    int en0;
    int lat;
    logic en_after;
    logic prev_done;
    logic [2:0] mode_bits;

    always #5 clk = ~clk;

    mul_issue_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .funct3_i      (funct3),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .rd_i          (rd),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_rd_o      (rsp_rd),
        .rsp_err_o     (rsp_err),
        .mult_en_o     (mult_en),
        .op_A_o        (op_a),
        .op_B_o        (op_b),
        .signed_A_o    (signed_a),
        .signed_B_o    (signed_b),
        .upper_o       (upper),
        .mult_done_i   (mult_done),
        .mult_result_i (mult_result)
    );

    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb, input logic up);
        logic signed [65:0] ea, eb, p;
        ea = sa ? {{34{a[31]}}, a} : {34'd0, a};
        eb = sb ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return up ? p[63:32] : p[31:0];
    endfunction

    // Seven cycles from the start pulse to the done pulse.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (rst) begin
            mdl_cnt <= 4'd0;
        end else if (mult_en) begin
            mdl_cnt <= 4'd7;
            mdl_res <= mul_model(op_a, op_b, signed_a, signed_b, upper);
        end else if (mdl_cnt != 4'd0) begin
            mdl_cnt <= mdl_cnt - 4'd1;
            if (mdl_cnt == 4'd1) mdl_done <= 1'b1;
        end
        if (mult_en) en_count <= en_count + 1;
    end

    assign mult_done   = mdl_done | stray_done;
    assign mult_result = stray_done ? 32'hDEADBEEF : mdl_res;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one request, then wait (bounded) for rsp_valid; lat counts edges from accept.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        funct3 = f3; rs1 = a; rs2 = b; rd = r;
        req_valid = 1'b1;
        en0 = en_count;
        step();
        req_valid = 1'b0;
        en_after = mult_en;
        mode_bits = {signed_a, signed_b, upper};
        lat = 1;
        prev_done = 1'b0;
        while (!rsp_valid && lat < 40) begin
            prev_done = mult_done;
            step();
            lat++;
        end
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        check("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mult_en",   32'(mult_en), 32'd0);
        check("rst_outs",      {26'd0, rsp_err, upper, signed_a, signed_b, 2'b00}, 32'd0);
        check("rst_rsp_data",  rsp_data, 32'd0);
        check("rst_op_a",      op_a, 32'd0);
        check("rst_op_b",      op_b, 32'd0);
        check("rst_rsp_rd",    32'(rsp_rd), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // MUL miss: start pulse right after accept, response right after done
        issue(3'b000, 32'd3, 32'hFFFFFFFE, 5'd1);
        check("mul_en_after_accept", 32'(en_after), 32'd1);
        check("mul_done_before_rsp", 32'(prev_done), 32'd1);
        check("mul_latency",  32'(lat), 32'd10);
        check("mul_data",     rsp_data, 32'hFFFFFFFA);
        check("mul_rd",       32'(rsp_rd), 32'd1);
        check("mul_err",      32'(rsp_err), 32'd0);
        check("mul_en_count", 32'(en_count - en0), 32'd1);
        handshake();

        issue(3'b001, 32'h80000000, 32'h80000000, 5'd2);
        check("mulh_mode", 32'(mode_bits), 32'd7);
        check("mulh_data", rsp_data, 32'h40000000);
        handshake();

        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        check("mulhsu_mode", 32'(mode_bits), 32'd5);
        check("mulhsu_data", rsp_data, 32'hFFFFFFFF);
        handshake();

        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        check("mulhu_mode", 32'(mode_bits), 32'd1);
        check("mulhu_data", rsp_data, 32'hFFFFFFFE);
        check("mulhu_en_count", 32'(en_count - en0), 32'd1);
        handshake();

        // Identical MULHU hits the cache
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
        check("hit_latency",  32'(lat), 32'd1);
        check("hit_en_after", 32'(en_after), 32'd0);
        check("hit_data",     rsp_data, 32'hFFFFFFFE);
        check("hit_rd",       32'(rsp_rd), 32'd5);
        check("hit_en_count", 32'(en_count - en0), 32'd0);
        handshake();

        // Same operands, funct3 changed to MUL: miss
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
        check("f3miss_en_count", 32'(en_count - en0), 32'd1);
        check("f3miss_data",     rsp_data, 32'h00000001);
        handshake();

        // DIV funct3: immediate error response
        issue(3'b100, 32'd100, 32'd7, 5'd7);
        check("div_latency",  32'(lat), 32'd1);
        check("div_err",      32'(rsp_err), 32'd1);
        check("div_data",     rsp_data, 32'd0);
        check("div_rd",       32'(rsp_rd), 32'd7);
        check("div_en_count", 32'(en_count - en0), 32'd0);
        handshake();

        // Consumer stalls for 5 cycles
        rsp_ready = 1'b0;
        issue(3'b000, 32'd5, 32'd7, 5'd9);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data",  rsp_data, 32'd35);
            check("stall_rd",    32'(rsp_rd), 32'd9);
            check("stall_ready", 32'(req_ready), 32'd0);
            step();
        end
        handshake();

        // Cache a result, then abandon a different op with reset during WAIT
        issue(3'b000, 32'h10, 32'h10, 5'd10);
        check("pre_abort_data", rsp_data, 32'h100);
        handshake();
        funct3 = 3'b000; rs1 = 32'd4; rs2 = 32'd4; rd = 5'd11;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_op_a",      op_a, 32'd0);
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stray_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        check("stray_ready", 32'(req_ready), 32'd1);

        issue(3'b000, 32'h10, 32'h10, 5'd12);
        check("post_abort_miss", 32'(en_count - en0), 32'd1);
        check("post_abort_data", rsp_data, 32'h100);
        check("post_abort_rd",   32'(rsp_rd), 32'd12);
        handshake();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
